// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush bubbles and MEM stall hold.
// Optional HAZARD_STATS_EN adds saturating load-use / flush bubble counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd_addr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              id_ex_r_valid,
  output logic [XLEN-1:0]   id_ex_r_pc,
  output logic [XLEN-1:0]   id_ex_r_rs1_data,
  output logic [XLEN-1:0]   id_ex_r_rs2_data,
  output logic [XLEN-1:0]   id_ex_r_imm,
  output logic [4:0]        id_ex_r_rs1_addr,
  output logic [4:0]        id_ex_r_rs2_addr,
  output logic [4:0]        id_ex_r_rd_addr,
  output logic [CTRL_W-1:0] id_ex_r_ctrl,
  output logic              id_ex_r_reg_write_en,
  output logic              stall_front
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_load_use,
  output logic [31:0]       stat_flush
`endif
);

  logic load_use;
  logic bubble;

  assign load_use = id_ex_r_valid & id_ex_r_ctrl[1] & (id_ex_r_rd_addr != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_ex_r_rd_addr == id_rs1_addr)) |
                     (id_uses_rs2 & (id_ex_r_rd_addr == id_rs2_addr)));
  assign bubble               = ex_flush | load_use;
  assign stall_front          = mem_stall | (load_use & ~ex_flush);
  assign id_ex_r_reg_write_en = id_ex_r_ctrl[0] & id_ex_r_valid;

  // Pipeline register: reset, hold on MEM stall, bubble on flush/load-use, else capture ID.
  always_ff @(posedge clk) begin
    if (!rst_n || (!mem_stall && bubble)) begin
      id_ex_r_valid    <= 1'b0;
      id_ex_r_pc       <= '0;
      id_ex_r_rs1_data <= '0;
      id_ex_r_rs2_data <= '0;
      id_ex_r_imm      <= '0;
      id_ex_r_rs1_addr <= '0;
      id_ex_r_rs2_addr <= '0;
      id_ex_r_rd_addr  <= '0;
      id_ex_r_ctrl     <= '0;
    end else if (!mem_stall) begin
      id_ex_r_valid    <= id_valid;
      id_ex_r_pc       <= id_pc;
      id_ex_r_rs1_data <= id_rs1_data;
      id_ex_r_rs2_data <= id_rs2_data;
      id_ex_r_imm      <= id_imm;
      id_ex_r_rs1_addr <= id_rs1_addr;
      id_ex_r_rs2_addr <= id_rs2_addr;
      id_ex_r_rd_addr  <= id_rd_addr;
      id_ex_r_ctrl     <= id_valid ? id_ctrl : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating bubble counters; flush takes precedence so a simultaneous hazard counts as a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_load_use <= '0;
      stat_flush    <= '0;
    end else if (!mem_stall) begin
      if (ex_flush && stat_flush != 32'hFFFF_FFFF) stat_flush <= stat_flush + 32'd1;
      if (!ex_flush && load_use && stat_load_use != 32'hFFFF_FFFF) stat_load_use <= stat_load_use + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
  localparam logic [9:0]  A = 10'h001;
  localparam logic [9:0]  L = 10'h04B;
  localparam logic [31:0] K = 32'h5A5A_0000;

  typedef struct {
    int          idx;
    logic        rst_n, v;
    logic [31:0] pc, rs1d;
    logic [4:0]  rs1a, rs2a;
    logic        u1, u2;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
    logic        ms, fl, sfc, sf;
    logic        e_v;
    logic [31:0] e_pc;
    logic [9:0]  e_ctrl;
    logic [4:0]  e_rd, e_rs1a;
    logic [31:0] e_rs1d;
    logic        e_rwe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, id_uses_rs1, id_uses_rs2, mem_stall, ex_flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [9:0]  id_ctrl;
  logic        id_ex_r_valid, id_ex_r_reg_write_en, stall_front;
  logic [31:0] id_ex_r_pc, id_ex_r_rs1_data, id_ex_r_rs2_data, id_ex_r_imm;
  logic [4:0]  id_ex_r_rs1_addr, id_ex_r_rs2_addr, id_ex_r_rd_addr;
  logic [9:0]  id_ex_r_ctrl;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_load_use, stat_flush;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CTRL_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_addr(id_rd_addr), .id_ctrl(id_ctrl), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_ex_r_valid(id_ex_r_valid), .id_ex_r_pc(id_ex_r_pc),
    .id_ex_r_rs1_data(id_ex_r_rs1_data), .id_ex_r_rs2_data(id_ex_r_rs2_data),
    .id_ex_r_imm(id_ex_r_imm), .id_ex_r_rs1_addr(id_ex_r_rs1_addr),
    .id_ex_r_rs2_addr(id_ex_r_rs2_addr), .id_ex_r_rd_addr(id_ex_r_rd_addr),
    .id_ex_r_ctrl(id_ex_r_ctrl), .id_ex_r_reg_write_en(id_ex_r_reg_write_en),
    .stall_front(stall_front)
`ifdef HAZARD_STATS_EN
    , .stat_load_use(stat_load_use), .stat_flush(stat_flush)
`endif
  );

  task automatic chk(input int i, input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s got %h expected %h", i, n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, v, input logic [31:0] pc, rs1d, input logic [4:0] rs1a, rs2a,
    input logic u1, u2, input logic [4:0] rd, input logic [9:0] ctrl, input logic ms, fl, sfc, sf,
    input logic ev, input logic [31:0] epc, input logic [9:0] ectrl,
    input logic [4:0] erd, ers1a, input logic [31:0] ers1d, input logic erwe);
    vec_t t;
    t.idx = 0; t.rst_n = r; t.v = v; t.pc = pc; t.rs1d = rs1d; t.rs1a = rs1a; t.rs2a = rs2a;
    t.u1 = u1; t.u2 = u2; t.rd = rd; t.ctrl = ctrl; t.ms = ms; t.fl = fl; t.sfc = sfc; t.sf = sf;
    t.e_v = ev; t.e_pc = epc; t.e_ctrl = ectrl; t.e_rd = erd; t.e_rs1a = ers1a;
    t.e_rs1d = ers1d; t.e_rwe = erwe;
    return t;
  endfunction

  initial begin
    // reset with a valid instruction on the inputs
    tbl.push_back(mk(0,1,'h100,'h11, 2,20,1,0, 1,A,0,0, 0,0, 0,'h0,  0, 0, 0,'h0, 0));
    tbl.push_back(mk(0,1,'h100,'h11, 2,20,1,0, 1,A,0,0, 1,0, 0,'h0,  0, 0, 0,'h0, 0));
    tbl.push_back(mk(1,1,'h100,'h11, 2,20,1,0, 1,A,0,0, 1,0, 1,'h100,A, 1, 2,'h11,1));
    // load-use on rs1: one bubble then consumer loads
    tbl.push_back(mk(1,1,'h104,'h22, 1,20,1,0, 5,L,0,0, 1,0, 1,'h104,L, 5, 1,'h22,1));
    tbl.push_back(mk(1,1,'h108,'h33, 5,20,1,0, 6,A,0,0, 1,1, 0,'h0,  0, 0, 0,'h0, 0));
    tbl.push_back(mk(1,1,'h108,'h33, 5,20,1,0, 6,A,0,0, 1,0, 1,'h108,A, 6, 5,'h33,1));
    // load to x0 never stalls
    tbl.push_back(mk(1,1,'h10C,'h44, 6,20,1,0, 0,L,0,0, 1,0, 1,'h10C,L, 0, 6,'h44,1));
    tbl.push_back(mk(1,1,'h110,'h55, 0,20,1,0, 7,A,0,0, 1,0, 1,'h110,A, 7, 0,'h55,1));
    // flush beats a load-use hazard on rs2
    tbl.push_back(mk(1,1,'h114,'h66, 3,20,1,0, 9,L,0,0, 1,0, 1,'h114,L, 9, 3,'h66,1));
    tbl.push_back(mk(1,1,'h118,'h67, 0, 9,0,1, 8,A,0,1, 1,0, 0,'h0,  0, 0, 0,'h0, 0));
    // load, then hazard under a 3-cycle mem_stall (flush ignored), bubble after release
    tbl.push_back(mk(1,1,'h120,'h77, 1,20,1,0,10,L,0,0, 1,0, 1,'h120,L,10, 1,'h77,1));
    tbl.push_back(mk(1,1,'h124,'h78,10,20,1,0,11,A,1,1, 1,1, 1,'h120,L,10, 1,'h77,1));
    tbl.push_back(mk(1,1,'h128,'h79,10,20,1,0,11,A,1,0, 1,1, 1,'h120,L,10, 1,'h77,1));
    tbl.push_back(mk(1,1,'h12C,'h7A,10,20,1,0,11,A,1,1, 1,1, 1,'h120,L,10, 1,'h77,1));
    tbl.push_back(mk(1,1,'h124,'h88,10,20,1,0,11,A,0,0, 1,1, 0,'h0,  0, 0, 0,'h0, 0));
    tbl.push_back(mk(1,1,'h124,'h88,10,20,1,0,11,A,0,0, 1,0, 1,'h124,A,11,10,'h88,1));
    // back-to-back independent adds
    tbl.push_back(mk(1,1,'h200,'h99,11,20,1,0,12,A,0,0, 1,0, 1,'h200,A,12,11,'h99,1));
    tbl.push_back(mk(1,1,'h204,'hAA,12,20,1,0,13,A,0,0, 1,0, 1,'h204,A,13,12,'hAA,1));
    // invalid ID loads with ctrl forced to 0 and never creates a hazard
    tbl.push_back(mk(1,0,'h208,'hBB,13,20,1,0,14,L,0,0, 1,0, 0,'h208,0,14,13,'hBB,0));
    tbl.push_back(mk(1,1,'h20C,'hCC,14,20,1,0,15,A,0,0, 1,0, 1,'h20C,A,15,14,'hCC,1));
    tbl.push_back(mk(1,1,'h210,'hDD, 0,20,1,0,16,L,0,0, 1,0, 1,'h210,L,16, 0,'hDD,1));
    tbl.push_back(mk(1,0,'h214,'hEE,16,20,1,0,17,A,0,0, 1,0, 0,'h214,0,17,16,'hEE,0));
    // reset mid-run
    tbl.push_back(mk(0,1,'h218,'hFF,17,20,1,0,18,L,0,0, 1,0, 0,'h0,  0, 0, 0,'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t, e;
      logic ld;
      t = tbl[i];
      t.idx = i;
      @(negedge clk);
      rst_n = t.rst_n; id_valid = t.v; id_pc = t.pc; id_imm = t.pc ^ K;
      id_rs1_data = t.rs1d; id_rs2_data = ~t.rs1d; id_rs1_addr = t.rs1a; id_rs2_addr = t.rs2a;
      id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; id_rd_addr = t.rd; id_ctrl = t.ctrl;
      mem_stall = t.ms; ex_flush = t.fl;
      #1;
      if (t.sfc) chk(i, "stall_front", {31'd0, stall_front}, {31'd0, t.sf});
      sb.push_back(t);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk(i, "scoreboard_empty", 32'd1, 32'd0);
        continue;
      end
      e = sb.pop_front();
      ld = (e.e_pc != 32'd0);
      chk(e.idx, "valid",    {31'd0, id_ex_r_valid},        {31'd0, e.e_v});
      chk(e.idx, "pc",       id_ex_r_pc,                    e.e_pc);
      chk(e.idx, "ctrl",     {22'd0, id_ex_r_ctrl},         {22'd0, e.e_ctrl});
      chk(e.idx, "rd",       {27'd0, id_ex_r_rd_addr},      {27'd0, e.e_rd});
      chk(e.idx, "rs1_addr", {27'd0, id_ex_r_rs1_addr},     {27'd0, e.e_rs1a});
      chk(e.idx, "rs2_addr", {27'd0, id_ex_r_rs2_addr},     ld ? 32'd20 : 32'd0);
      chk(e.idx, "rs1_data", id_ex_r_rs1_data,              e.e_rs1d);
      chk(e.idx, "rs2_data", id_ex_r_rs2_data,              ld ? ~e.e_rs1d : 32'd0);
      chk(e.idx, "imm",      id_ex_r_imm,                   ld ? (e.e_pc ^ K) : 32'd0);
      chk(e.idx, "rwe",      {31'd0, id_ex_r_reg_write_en}, {31'd0, e.e_rwe});
`ifdef HAZARD_STATS_EN
      if (i == 21) begin
        chk(i, "stat_flush",    stat_flush,    32'd1);
        chk(i, "stat_load_use", stat_load_use, 32'd2);
      end
      if (i == 22) begin
        chk(i, "stat_flush_rst",    stat_flush,    32'd0);
        chk(i, "stat_load_use_rst", stat_load_use, 32'd0);
      end
`endif
    end
    chk(-1, "scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
